// File: rtl/irq_line_conditioner.sv
// irq_line_conditioner
//
// Conditions the raw peripheral interrupt lines before they reach the PLIC.
// Each line is synchronized into the clock domain. The GPIO In line is also
// glitch-filtered. Each line is then either passed as a level or turned into
// a stretched pulse on its rising edge.
//
// Ports:
//   clock_i            system clock
//   reset_i            synchronous active-high reset
//   gpioin_irq_i       GPIO In interrupt (asynchronous)   -> plic_irq_o[1]
//   tim0_irq_i         Timer 0 interrupt                  -> plic_irq_o[2]
//   tim1_irq_i         Timer 1 interrupt                  -> plic_irq_o[3]
//   uart_irq_i         UART interrupt                     -> plic_irq_o[4]
//   hls_irq_i          HLS core interrupt                 -> plic_irq_o[5]
//   cdma_irq_i         CDMA interrupt                     -> plic_irq_o[6]
//   plic_irq_o[31:0]   PLIC source vector, registered (bits 0 and 7..31 are tied to 0)
//
// Optional feature, macro IRQ_LINE_COUNTERS_EN. It adds one rising-edge event
// counter per line and these ports:
//   irq_count_clear_i  clears all event counters (wins over a coincident edge)
//   irq_count_sel_i    PLIC line select (1..6 mapped, others read 0)
//   irq_count_o        registered counter value for the selected line

module irq_line_conditioner #(
    parameter int          SYNC_STAGES       = 2,
    parameter int          FILTER_CYCLES     = 8,
    parameter int          PULSE_HOLD_CYCLES = 4,
    parameter logic [31:0] EDGE_MASK         = 32'h0000_0040
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        gpioin_irq_i,
    input  logic        tim0_irq_i,
    input  logic        tim1_irq_i,
    input  logic        uart_irq_i,
    input  logic        hls_irq_i,
    input  logic        cdma_irq_i,
    output logic [31:0] plic_irq_o
`ifdef IRQ_LINE_COUNTERS_EN
    ,
    input  logic        irq_count_clear_i,
    input  logic [4:0]  irq_count_sel_i,
    output logic [15:0] irq_count_o
`endif
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int HW = $clog2(PULSE_HOLD_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(PULSE_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [6:1]                  raw;
    logic [SYNC_STAGES-1:0][6:1] sync_p;
    logic [6:1]                  synced;
    logic                        filt_q;
    logic [FW-1:0]               fcnt;
    logic [6:1]                  cond;
    logic [6:1]                  prev_p1;
    logic [6:1]                  rise;
    logic [HW-1:0]               hcnt [1:6];
    logic [6:1]                  plic_next;

    assign raw    = {cdma_irq_i, hls_irq_i, uart_irq_i, tim1_irq_i, tim0_irq_i, gpioin_irq_i};
    assign synced = sync_p[SYNC_STAGES-1];

    // Synchronizer: stage 0 takes the raw lines, the last stage feeds logic.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
        end
    end

    // GPIO glitch filter: the line changes only after FILTER_CYCLES
    // consecutive cycles of disagreement. Any agreement restarts the count.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            filt_q <= 1'b0;
            fcnt   <= '0;
        end else if (synced[1] != filt_q) begin
            if (fcnt == FILT_LAST) begin
                filt_q <= synced[1];
                fcnt   <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end else begin
            fcnt <= '0;
        end
    end

    assign cond = {synced[6:2], filt_q};
    assign rise = cond & ~prev_p1;

    // Edge detect history and pulse hold counters (edge reloads = retrigger).
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            prev_p1 <= '0;
            for (int k = 1; k <= 6; k++) begin
                hcnt[k] <= '0;
            end
        end else begin
            prev_p1 <= cond;
            for (int k = 1; k <= 6; k++) begin
                if (rise[k]) begin
                    hcnt[k] <= HOLD_LOAD;
                end else if (hcnt[k] != '0) begin
                    hcnt[k] <= hcnt[k] - 1'b1;
                end
            end
        end
    end

    // Edge lines stay high for the load cycle plus while hcnt > 1, which
    // totals PULSE_HOLD_CYCLES cycles of output.
    always_comb begin
        plic_next = '0;
        for (int k = 1; k <= 6; k++) begin
            plic_next[k] = EDGE_MASK[k] ? (rise[k] | (hcnt[k] > HOLD_ONE)) : cond[k];
        end
    end

    // Output register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            plic_irq_o <= '0;
        end else begin
            plic_irq_o <= {25'b0, plic_next, 1'b0};
        end
    end

`ifdef IRQ_LINE_COUNTERS_EN
    logic [15:0] evt_cnt [1:6];

    // Saturating event counters; clear has priority over a same-cycle edge.
    always_ff @(posedge clock_i) begin
        if (reset_i || irq_count_clear_i) begin
            for (int k = 1; k <= 6; k++) begin
                evt_cnt[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= 6; k++) begin
                if (rise[k] && (evt_cnt[k] != 16'hFFFF)) begin
                    evt_cnt[k] <= evt_cnt[k] + 16'd1;
                end
            end
        end
    end

    // Registered read-out
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            irq_count_o <= '0;
        end else begin
            case (irq_count_sel_i)
                5'd1:    irq_count_o <= evt_cnt[1];
                5'd2:    irq_count_o <= evt_cnt[2];
                5'd3:    irq_count_o <= evt_cnt[3];
                5'd4:    irq_count_o <= evt_cnt[4];
                5'd5:    irq_count_o <= evt_cnt[5];
                5'd6:    irq_count_o <= evt_cnt[6];
                default: irq_count_o <= '0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_irq_line_conditioner.sv
// Testbench for irq_line_conditioner (default parameters).
// Each table record describes one scenario. The scenario gives the pulses on
// one input line, an optional mid-run reset, and the window in which the
// matching PLIC bit must be high. Cycle 0 is the first cycle after reset
// release. An input driven in cycle t is sampled at the clock edge that ends
// cycle t. Outputs are sampled at the falling edge.

module tb_irq_line_conditioner;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        gpioin_irq_i, tim0_irq_i, tim1_irq_i, uart_irq_i, hls_irq_i, cdma_irq_i;
    logic [31:0] plic_irq_o;
`ifdef IRQ_LINE_COUNTERS_EN
    logic        irq_count_clear_i;
    logic [4:0]  irq_count_sel_i;
    logic [15:0] irq_count_o;
`endif

    always #5 clock_i = ~clock_i;

    irq_line_conditioner dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .gpioin_irq_i (gpioin_irq_i),
        .tim0_irq_i   (tim0_irq_i),
        .tim1_irq_i   (tim1_irq_i),
        .uart_irq_i   (uart_irq_i),
        .hls_irq_i    (hls_irq_i),
        .cdma_irq_i   (cdma_irq_i),
        .plic_irq_o   (plic_irq_o)
`ifdef IRQ_LINE_COUNTERS_EN
        ,
        .irq_count_clear_i (irq_count_clear_i),
        .irq_count_sel_i   (irq_count_sel_i),
        .irq_count_o       (irq_count_o)
`endif
    );

    typedef struct {
        string name;
        int    line;
        int    in1_start;
        int    in1_len;
        int    in2_start;
        int    in2_len;
        int    rst_cyc;
        int    exp_start;
        int    exp_len;
        int    ncyc;
    } vec_t;

    localparam int NV = 11;
    vec_t        vecs [NV];
    logic [31:0] sb_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit in_win(input int t, input int s, input int l);
        return (t >= s) && (t < s + l);
    endfunction

    function automatic logic [6:1] stim_at(input vec_t v, input int t);
        logic [6:1] r;
        r = '0;
        if (in_win(t, v.in1_start, v.in1_len) || in_win(t, v.in2_start, v.in2_len)) r[v.line] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_at(input vec_t v, input int t);
        logic [31:0] r;
        r = '0;
        if (in_win(t, v.exp_start, v.exp_len)) r[v.line] = 1'b1;
        return r;
    endfunction

    task automatic apply_inputs(input logic [6:1] v);
        gpioin_irq_i = v[1];
        tim0_irq_i   = v[2];
        tim1_irq_i   = v[3];
        uart_irq_i   = v[4];
        hls_irq_i    = v[5];
        cdma_irq_i   = v[6];
    endtask

    // Two reset edges with the given inputs held, returns at the negedge of cycle 0.
    task automatic do_reset(input logic [6:1] v);
        @(negedge clock_i);
        reset_i = 1'b1;
        apply_inputs(v);
        @(negedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] e;
        do_reset(stim_at(v, 0));
        sb_q.delete();
        sb_q.push_back(exp_at(v, 0));
        for (int t = 0; t < v.ncyc; t++) begin
            e = sb_q.pop_front();
            check($sformatf("%s cyc%0d", v.name, t), plic_irq_o, e);
            reset_i = (t == v.rst_cyc);
            apply_inputs(stim_at(v, t));
            sb_q.push_back(exp_at(v, t + 1));
            @(negedge clock_i);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        apply_inputs('0);
`ifdef IRQ_LINE_COUNTERS_EN
        irq_count_clear_i = 1'b0;
        irq_count_sel_i   = 5'd2;
`endif
        //          name           line in1   len in2 len rst  exp  len ncyc
        vecs[0]  = '{"idle",        4,  0,  0,  0, 0, -1,  0,  0, 20};
        vecs[1]  = '{"uart_level",  4, 10, 20,  0, 0, -1, 13, 20, 40};
        vecs[2]  = '{"hls_level",   5,  5,  3,  0, 0, -1,  8,  3, 15};
        vecs[3]  = '{"tim1_1cyc",   3,  7,  1,  0, 0, -1, 10,  1, 15};
        vecs[4]  = '{"gpio_glitch", 1, 10,  5,  0, 0, -1,  0,  0, 40};
        vecs[5]  = '{"gpio_held",   1, 10, 30,  0, 0, -1, 21, 30, 60};
        vecs[6]  = '{"cdma_pulse",  6, 10,  1,  0, 0, -1, 13,  4, 25};
        vecs[7]  = '{"cdma_retrig", 6, 10,  1, 12, 1, -1, 13,  6, 25};
        vecs[8]  = '{"cdma_long",   6, 10, 10,  0, 0, -1, 13,  4, 30};
        vecs[9]  = '{"cdma_rst",    6, 10,  1,  0, 0, 14, 13,  2, 30};
        vecs[10] = '{"cdma_inrst",  6,  0, 30,  0, 0, -1,  3,  4, 30};

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

`ifdef IRQ_LINE_COUNTERS_EN
        do_reset('0);
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tim0_irq_i = 1'b1;
            repeat (2) @(negedge clock_i);
            tim0_irq_i = 1'b0;
            repeat (2) @(negedge clock_i);
        end
        repeat (5) @(negedge clock_i);
        check("count_tim0_3", {16'h0, irq_count_o}, 32'd3);
        irq_count_sel_i = 5'd9;
        repeat (2) @(negedge clock_i);
        check("count_sel9", {16'h0, irq_count_o}, 32'd0);
        irq_count_sel_i = 5'd2;
        repeat (2) @(negedge clock_i);
        check("count_tim0_reread", {16'h0, irq_count_o}, 32'd3);
        // The 4th edge reaches the counter two cycles after the input rises.
        tim0_irq_i = 1'b1;
        repeat (2) @(negedge clock_i);
        irq_count_clear_i = 1'b1;
        @(negedge clock_i);
        irq_count_clear_i = 1'b0;
        repeat (4) @(negedge clock_i);
        check("count_clear_edge", {16'h0, irq_count_o}, 32'd0);
        tim0_irq_i = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_line_conditioner.md
Name: irq_line_conditioner

Overview:
- Sits directly upstream of the platform interrupt controller (PLIC). Collects raw interrupt lines from PBUS peripherals, the HLS core and the CDMA.
- Each line is synchronized, optionally glitch-filtered (GPIO In only), and level-passed or edge-stretched.
- Drives the fixed 32-line PLIC source vector in the static platform mapping.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per input line (>=2).
- FILTER_CYCLES, 8, consecutive stable cycles required before the GPIO In line changes value (>=1).
- PULSE_HOLD_CYCLES, 4, output high time for an edge-mode line (>=1).
- EDGE_MASK, 32'h0000_0040, per PLIC line: 1 = edge mode (stretched pulse), 0 = level mode.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- gpioin_irq_i  in  1  GPIO In interrupt (async)
- tim0_irq_i  in  1  Timer 0 interrupt
- tim1_irq_i  in  1  Timer 1 interrupt
- uart_irq_i  in  1  UART interrupt
- hls_irq_i  in  1  HLS core interrupt
- cdma_irq_i  in  1  CDMA interrupt
- plic_irq_o  out  32  PLIC interrupt source vector

Behaviour:
- Interface (already decided): one clock, clock_i; reset_i is synchronous and active-high.
- Mapping of plic_irq_o:
  - bit0 constant 0 (reserved).
  - bit1 gpioin, bit2 tim0, bit3 tim1, bit4 uart, bit5 hls, bit6 cdma.
  - bits 7..31 constant 0; EDGE_MASK bits 0 and 7..31 are ignored.
- Reset: all sync flops, filter state, previous-value regs, hold counters and plic_irq_o cleared to 0 on the first clock edge with reset_i=1. Reset mid-pulse aborts the pulse; the output is 0 the cycle after.
- Sync: each input passes through SYNC_STAGES flops, giving s[k].
- GPIO filter (line 1 only):
  - Filtered value f starts at 0; counter fcnt has width $clog2(FILTER_CYCLES+1).
  - If s != f: fcnt increments. When fcnt reaches FILTER_CYCLES-1 and s still != f, then f <= s and fcnt <= 0.
  - If s == f: fcnt <= 0.
  - Any single-cycle disagreement restarts the count. Lines 2..6 use c = s with no filter.
- Level mode: plic_irq_o[k] <= c[k] each cycle. Latency from a stable input to output is SYNC_STAGES+1 cycles, plus FILTER_CYCLES for line 1.
- Edge mode:
  - p[k] <= c[k]; a rising edge is detected when c & ~p.
  - On an edge, hold counter hcnt is loaded with PULSE_HOLD_CYCLES. Otherwise, if hcnt != 0, it decrements.
  - plic_irq_o[k] <= (edge | hcnt > 1). The output is high for exactly PULSE_HOLD_CYCLES cycles, starting the same cycle a level line would rise.
  - An edge during an active pulse reloads the counter (retrigger), so the pulse extends to PULSE_HOLD_CYCLES after the new edge.
  - Falling edges are ignored. A line already high when reset deasserts yields one pulse.
- No combinational path from any input to plic_irq_o.

Optional Feature:
- Macro IRQ_LINE_COUNTERS_EN.
- When defined, add ports:
  - irq_count_clear_i  in  1  clears all event counters
  - irq_count_sel_i  in  5  PLIC line select
  - irq_count_o  out  16  counter value for the selected line
- Counter behaviour:
  - Lines 1..6 each have a 16-bit counter, incremented on each rising edge of c (post-filter) in both modes.
  - Counters saturate at 16'hFFFF. Clear has priority over a simultaneous edge (result 0). Reset value is 0.
  - irq_count_o is registered (1-cycle read latency); unmapped selects return 0.
- When undefined: no ports, no counters; behaviour otherwise identical.

Test Plan:
1. Reset then idle, all inputs 0 for 20 cycles -> plic_irq_o == 32'h0 throughout.
2. Level: uart_irq_i rises at cycle 10 -> plic_irq_o[4]=1 from cycle 13. It deasserts at 30 -> plic_irq_o[4]=0 from 33.
3. GPIO filter, FILTER_CYCLES=8:
   - 5-cycle high glitch -> bit1 never rises.
   - Held high from cycle 10 -> bit1 rises at cycle 21.
4. Edge, CDMA: 1-cycle pulse at cycle 10 -> bit6 high cycles 13..16 exactly.
   - Second pulse at cycle 12 -> bit6 high cycles 13..18.
5. Reset mid-pulse: reset_i=1 at cycle 14 during case 4 -> bit6=0 from cycle 15; no pulse afterwards while the input stays 0.
6. IRQ_LINE_COUNTERS_EN:
   - 3 tim0 rising edges, sel=2 -> irq_count_o=3.
   - Clear coincident with a 4th edge -> 0.
   - sel=9 -> 0.
